// File: rtl/motor_pwm_driver.sv
// Dual-channel (left/right) motor driver: slew-limited duty ramps plus a PWM output.
// A channel reverses direction only from duty 0 and only after a dead time has elapsed.
module motor_pwm_driver #(
    parameter int unsigned PRESCALE    = 10,
    parameter int unsigned RAMP_DIV    = 50000,
    parameter int unsigned RAMP_STEP   = 16,
    parameter int unsigned DEAD_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] instruction,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic [7:0] duty_l,
    output logic [7:0] duty_r,
    output logic       busy
);
    localparam int unsigned PreW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned RampW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DeadW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [PreW-1:0]  PreMax   = PreW'(PRESCALE - 1);
    localparam logic [RampW-1:0] RampMax  = RampW'(RAMP_DIV - 1);
    localparam logic [DeadW-1:0] DeadLoad = DeadW'(DEAD_CYCLES - 1);
    localparam logic [7:0]       Step     = 8'(RAMP_STEP);

    typedef enum logic [1:0] {StIdle, StDrive, StStop, StDead} ch_state_e;

    // Index 0 is the left channel, index 1 the right channel.
    ch_state_e        state_q [2];
    ch_state_e        state_d [2];
    logic [1:0]       dir_q, dir_d;
    logic [7:0]       duty_q  [2];
    logic [7:0]       duty_d  [2];
    logic [DeadW-1:0] dead_q  [2];
    logic [DeadW-1:0] dead_d  [2];

    logic [7:0]       mag;
    logic [7:0]       tgt [2];
    logic [1:0]       tdir;

    logic [PreW-1:0]  pre_q;
    logic [RampW-1:0] ramp_q;
    logic [7:0]       cnt_q;
    logic [7:0]       active_q [2];
    logic [1:0]       pwm_q;
    logic             tick, pwm_step;

    assign tick     = (ramp_q == RampMax);
    assign pwm_step = (pre_q == PreMax);

    always_comb begin
        case (instruction[3:2])
            2'd0:    mag = 8'd64;
            2'd1:    mag = 8'd128;
            2'd2:    mag = 8'd192;
            default: mag = 8'd255;
        endcase
        case (instruction[1:0])
            2'b00:   tdir = 2'b00;
            2'b01:   tdir = 2'b11;
            2'b10:   tdir = 2'b01;
            default: tdir = 2'b10;
        endcase
        tgt[0] = enable ? mag : 8'd0;
        tgt[1] = enable ? mag : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StIdle;
                duty_q[i]  <= '0;
                dead_q[i]  <= '0;
            end
            dir_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                duty_q[i]  <= duty_d[i];
                dead_q[i]  <= dead_d[i];
            end
            dir_q <= dir_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                StIdle: begin
                    if (tgt[i] != 8'd0) state_d[i] = (tdir[i] == dir_q[i]) ? StDrive : StDead;
                end
                StDrive: begin
                    if (tgt[i] == 8'd0 || tdir[i] != dir_q[i]) state_d[i] = StStop;
                end
                StStop: begin
                    if (duty_q[i] == 8'd0) begin
                        state_d[i] = StIdle;
                    end else if (tgt[i] != 8'd0 && tdir[i] == dir_q[i]) begin
                        state_d[i] = StDrive;
                    end
                end
                StDead: begin
                    if (dead_q[i] == '0 || tdir[i] == dir_q[i]) state_d[i] = StIdle;
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    // Duty stepping follows the next state, so a target change on a tick cycle steps at once.
    always_comb begin
        logic [8:0] up;
        up    = '0;
        dir_d = dir_q;
        for (int i = 0; i < 2; i++) begin
            duty_d[i] = duty_q[i];
            dead_d[i] = dead_q[i];
            up        = {1'b0, duty_q[i]} + {1'b0, Step};
            if (state_q[i] == StDead) begin
                if (dead_q[i] == '0) begin
                    dir_d[i] = tdir[i];
                end else begin
                    dead_d[i] = dead_q[i] - DeadW'(1);
                end
            end else if (state_d[i] == StDead) begin
                dead_d[i] = DeadLoad;
            end
            case (state_d[i])
                StDrive: begin
                    if (tick) begin
                        if (duty_q[i] < tgt[i]) begin
                            duty_d[i] = (up >= {1'b0, tgt[i]}) ? tgt[i] : up[7:0];
                        end else if (duty_q[i] > tgt[i]) begin
                            duty_d[i] = (duty_q[i] - tgt[i] > Step) ? duty_q[i] - Step : tgt[i];
                        end
                    end
                end
                StStop: begin
                    if (tick) duty_d[i] = (duty_q[i] > Step) ? duty_q[i] - Step : 8'd0;
                end
                default: duty_d[i] = '0;
            endcase
        end
    end

    assign busy = (state_q[0] != StIdle) || (state_q[1] != StIdle);

    // Active duty only changes at the period wrap so a PWM period is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            ramp_q <= '0;
            cnt_q  <= '0;
            pwm_q  <= '0;
            for (int i = 0; i < 2; i++) active_q[i] <= '0;
        end else begin
            ramp_q <= tick ? '0 : ramp_q + RampW'(1);
            pre_q  <= pwm_step ? '0 : pre_q + PreW'(1);
            if (pwm_step) begin
                cnt_q <= cnt_q + 8'd1;
                if (cnt_q == 8'hff) begin
                    for (int i = 0; i < 2; i++) active_q[i] <= duty_q[i];
                end
            end
            for (int i = 0; i < 2; i++) pwm_q[i] <= (cnt_q < active_q[i]);
        end
    end

    assign pwm_l  = pwm_q[0];
    assign pwm_r  = pwm_q[1];
    assign dir_l  = dir_q[0];
    assign dir_r  = dir_q[1];
    assign duty_l = duty_q[0];
    assign duty_r = duty_q[1];

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: directed scenarios plus randomized instruction
// streams, all compared every cycle against a behavioural model of the drive rules.
module tb_motor_pwm_driver;
    localparam int PRESCALE    = 1;
    localparam int RAMP_DIV    = 4;
    localparam int RAMP_STEP   = 16;
    localparam int DEAD_CYCLES = 8;

    localparam int MIdle  = 0;
    localparam int MDrive = 1;
    localparam int MStop  = 2;
    localparam int MDead  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] instruction = 4'd0;
    logic       pwm_l, pwm_r, dir_l, dir_r, busy;
    logic [7:0] duty_l, duty_r;
    logic [20:0] dut_vec;

    int n_checks = 0;
    int n_fail = 0;

    int m_mode[2], m_rem[2], m_duty[2], m_dir[2], m_active[2], m_pwm[2];
    int m_cnt, m_pre, m_ramp;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .PRESCALE   (PRESCALE),
        .RAMP_DIV   (RAMP_DIV),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .instruction(instruction),
        .pwm_l      (pwm_l),
        .pwm_r      (pwm_r),
        .dir_l      (dir_l),
        .dir_r      (dir_r),
        .duty_l     (duty_l),
        .duty_r     (duty_r),
        .busy       (busy)
    );

    assign dut_vec = {pwm_l, pwm_r, dir_l, dir_r, duty_l, duty_r, busy};

    function automatic logic [20:0] exp_vec();
        return {m_pwm[0] != 0, m_pwm[1] != 0, m_dir[0] != 0, m_dir[1] != 0,
                8'(m_duty[0]), 8'(m_duty[1]), (m_mode[0] != MIdle) || (m_mode[1] != MIdle)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = MIdle; m_rem[i] = 0; m_duty[i] = 0;
            m_dir[i] = 0; m_active[i] = 0; m_pwm[i] = 0;
        end
        m_cnt = 0; m_pre = 0; m_ramp = 0;
    endtask

    // One clock of behaviour, evaluated from the inputs present at the coming edge.
    task automatic model_advance();
        int  tg, td, nm;
        bit  tick, pstep;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tg = !enable ? 0 :
             (instruction[3:2] == 2'd3) ? 255 : 64 * (int'(instruction[3:2]) + 1);
        tick  = (m_ramp == RAMP_DIV - 1);
        pstep = (m_pre == PRESCALE - 1);
        m_ramp = tick ? 0 : m_ramp + 1;
        m_pre  = pstep ? 0 : m_pre + 1;
        for (int i = 0; i < 2; i++) begin
            m_pwm[i] = (m_cnt < m_active[i]) ? 1 : 0;
            if (pstep && m_cnt == 255) m_active[i] = m_duty[i];
        end
        if (pstep) m_cnt = (m_cnt + 1) % 256;
        for (int i = 0; i < 2; i++) begin
            td = (instruction[1:0] == 2'b01 ||
                  instruction[1:0] == ((i == 0) ? 2'b10 : 2'b11)) ? 1 : 0;
            nm = m_mode[i];
            if (m_mode[i] == MIdle && tg > 0) begin
                nm = (td == m_dir[i]) ? MDrive : MDead;
                if (nm == MDead) m_rem[i] = DEAD_CYCLES;
            end else if (m_mode[i] == MDrive && (tg == 0 || td != m_dir[i])) begin
                nm = MStop;
            end else if (m_mode[i] == MStop) begin
                if (m_duty[i] == 0) nm = MIdle;
                else if (tg > 0 && td == m_dir[i]) nm = MDrive;
            end else if (m_mode[i] == MDead) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_dir[i] = td;
                    nm = MIdle;
                end else if (td == m_dir[i]) begin
                    nm = MIdle;
                end
            end
            m_mode[i] = nm;
            if (nm == MDrive && tick) begin
                if (m_duty[i] < tg) m_duty[i] = (m_duty[i] + RAMP_STEP > tg) ? tg : m_duty[i] + RAMP_STEP;
                else m_duty[i] = (m_duty[i] - RAMP_STEP < tg) ? tg : m_duty[i] - RAMP_STEP;
            end else if (nm == MStop && tick) begin
                m_duty[i] = (m_duty[i] < RAMP_STEP) ? 0 : m_duty[i] - RAMP_STEP;
            end else if (nm == MIdle || nm == MDead) begin
                m_duty[i] = 0;
            end
        end
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        enable = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        instruction = 4'd0;
        model_reset();
        repeat (3) step();
        n_checks++;
        if (dut_vec !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", dut_vec, 21'd0);
        end
        rst_n = 1'b1;
        repeat (100) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle t=%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (dut_vec !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_idle_end: got %h expected %h", dut_vec, 21'd0);
        end
    endtask

    task automatic test_ramp_up();
        int highs_l, highs_r;
        enable = 1'b1;
        instruction = 4'b1100;
        repeat (70 + 256) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL ramp_up t=%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
        end
        highs_l = 0;
        highs_r = 0;
        repeat (256) begin
            step();
            highs_l += int'(pwm_l);
            highs_r += int'(pwm_r);
        end
        n_checks++;
        if (duty_l !== 8'd255 || duty_r !== 8'd255 || dir_l !== 1'b0 || dir_r !== 1'b0 ||
            busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_up_final: got duty %0d/%0d dir %b%b busy %b expected 255/255 00 1",
                     duty_l, duty_r, dir_l, dir_r, busy);
        end
        n_checks++;
        if (highs_l != 255 || highs_r != 255) begin
            n_fail++;
            $display("FAIL pwm_full_period: got high %0d/%0d expected 255/255", highs_l, highs_r);
        end
    endtask

    task automatic test_reverse();
        int  zero_run;
        bit  flip_seen, flip_ok;
        logic prev_dir;
        zero_run = 0;
        flip_seen = 1'b0;
        flip_ok = 1'b1;
        prev_dir = dir_l;
        instruction = 4'b0001;
        repeat (200) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reverse t=%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
            if (dir_l !== prev_dir) begin
                flip_seen = 1'b1;
                if (zero_run < DEAD_CYCLES || duty_l !== 8'd0) flip_ok = 1'b0;
            end
            zero_run = (duty_l == 8'd0) ? zero_run + 1 : 0;
            prev_dir = dir_l;
        end
        n_checks++;
        if (!flip_seen || !flip_ok) begin
            n_fail++;
            $display("FAIL reverse_dead_time: got seen=%0d ok=%0d expected 1/1", flip_seen, flip_ok);
        end
        n_checks++;
        if (duty_l !== 8'd64 || duty_r !== 8'd64 || dir_l !== 1'b1 || dir_r !== 1'b1) begin
            n_fail++;
            $display("FAIL reverse_final: got duty %0d/%0d dir %b%b expected 64/64 11",
                     duty_l, duty_r, dir_l, dir_r);
        end
    endtask

    task automatic test_left_turn();
        bit r_dir_ok;
        r_dir_ok = 1'b1;
        pulse_reset();
        enable = 1'b1;
        instruction = 4'b1010;
        repeat (80) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL left_turn t=%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
            if (dir_r !== 1'b0) r_dir_ok = 1'b0;
        end
        n_checks++;
        if (duty_l !== 8'd192 || duty_r !== 8'd192 || dir_l !== 1'b1 || !r_dir_ok) begin
            n_fail++;
            $display("FAIL left_turn_final: got duty %0d/%0d dir_l %b r_ok %0d expected 192/192 1 1",
                     duty_l, duty_r, dir_l, r_dir_ok);
        end
    endtask

    task automatic test_enable_drop();
        bit   reached;
        int   drops;
        logic [7:0] prev;
        reached = 1'b0;
        pulse_reset();
        enable = 1'b1;
        instruction = 4'b0100;
        for (int c = 0; c < 100 && !reached; c++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL enable_rise t=%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
            if (duty_l == 8'd96) reached = 1'b1;
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL enable_reach96: got duty %0d expected 96 within 100 clks", duty_l);
        end
        enable = 1'b0;
        drops = 0;
        prev = duty_l;
        for (int c = 0; c < 100 && busy !== 1'b0; c++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL enable_drop t=%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
            if (duty_l < prev) drops++;
            prev = duty_l;
        end
        n_checks++;
        if (busy !== 1'b0 || duty_l !== 8'd0 || drops != 6) begin
            n_fail++;
            $display("FAIL enable_drop_final: got busy %b duty %0d steps %0d expected 0 0 6",
                     busy, duty_l, drops);
        end
    endtask

    task automatic test_async_reset();
        bit reached;
        reached = 1'b0;
        pulse_reset();
        enable = 1'b1;
        instruction = 4'b1100;
        for (int c = 0; c < 100 && !reached; c++) begin
            step();
            if (duty_l == 8'd128) reached = 1'b1;
        end
        n_checks++;
        if (!reached || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_pre: got %h reached %0d expected %h 1", dut_vec, reached, exp_vec());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h expected %h", dut_vec, 21'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL async_recover t=%0t: got %h expected %h", $time, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic pdl, pdr;
        logic [7:0] pul, pur;
        for (int seg = 0; seg < 40; seg++) begin
            enable = ($urandom_range(0, 3) != 0);
            instruction = 4'($urandom);
            repeat ($urandom_range(1, 80)) begin
                pdl = dir_l; pdr = dir_r; pul = duty_l; pur = duty_r;
                step();
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random seg=%0d t=%0t: got %h expected %h",
                             seg, $time, dut_vec, exp_vec());
                end
                if (dir_l !== pdl || dir_r !== pdr) begin
                    n_checks++;
                    if ((dir_l !== pdl && (pul !== 8'd0 || duty_l !== 8'd0)) ||
                        (dir_r !== pdr && (pur !== 8'd0 || duty_r !== 8'd0))) begin
                        n_fail++;
                        $display("FAIL random_dir_flip: got duty %0d/%0d at flip expected 0/0",
                                 duty_l, duty_r);
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp_up();
        test_reverse();
        test_left_turn();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
